// File: rtl/branch_predictor_pkg.sv
// Shared constants and types for the branch predictor: datapath width, table
// geometry and the 2-bit bimodal counter encoding.
package branch_predictor_pkg;

    localparam int WORD        = 32;
    localparam int BP_IDX_BITS = 6;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam ctr_e BP_CTR_INIT  = CTR_WNT;
    localparam ctr_e BP_CTR_ALLOC = CTR_WT;

endpackage

// File: rtl/branch_predictor_sat_ctr2.sv
// Combinational next-state for a 2-bit saturating up/down direction counter.
module sat_ctr2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       up,
    output logic [1:0] ctr_next
);

    // NOTE: ctr_next gets a default before any branch so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        ctr_next = ctr;
        if (up) begin
            if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit bimodal direction counters: combinational IF-side
// lookup, EX-side update, plus resolved-branch and misprediction counters.
module branch_predictor #(
    parameter int WORD     = branch_predictor_pkg::WORD,
    parameter int IDX_BITS = branch_predictor_pkg::BP_IDX_BITS,
    parameter int TAG_BITS = WORD - IDX_BITS - 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WORD-1:0] if_pc,
    output logic            pred_taken,
    output logic [WORD-1:0] pred_pc,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic [WORD-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [WORD-1:0] ex_target,
    input  logic            ex_mispredict,
    output logic [31:0]     br_cnt,
    output logic [31:0]     mp_cnt
);

    import branch_predictor_pkg::*;

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_BITS-1:0] tag_q [ENTRIES];
    logic [WORD-1:0]     tgt_q [ENTRIES];
    logic [1:0]          ctr_q [ENTRIES];

    // ---------------- IF-side lookup (reads pre-update state) ----------------
    logic [IDX_BITS-1:0] rd_idx;
    logic [TAG_BITS-1:0] rd_tag;
    logic                rd_hit;
    logic [WORD-1:0]     seq_pc;
    logic [WORD-1:0]     raw_pc;

    assign rd_idx     = if_pc[IDX_BITS+1:2];
    assign rd_tag     = if_pc[WORD-1:IDX_BITS+2];
    assign rd_hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign pred_taken = rd_hit && ctr_q[rd_idx][1];
    assign seq_pc     = if_pc + WORD'(4);
    assign raw_pc     = pred_taken ? tgt_q[rd_idx] : seq_pc;
    assign pred_pc    = {raw_pc[WORD-1:2], 2'b00};

    // ---------------- EX-side update ----------------
    logic [IDX_BITS-1:0] wr_idx;
    logic [TAG_BITS-1:0] wr_tag;
    logic                wr_hit;
    logic                upd;
    logic [1:0]          ctr_next;

    assign upd    = ex_valid && ex_is_branch;
    assign wr_idx = ex_pc[IDX_BITS+1:2];
    assign wr_tag = ex_pc[WORD-1:IDX_BITS+2];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    sat_ctr2 u_sat_ctr2 (
        .ctr      (ctr_q[wr_idx]),
        .up       (ex_taken),
        .ctr_next (ctr_next)
    );

    // NOTE: the whole table sits in flops with an async clear, so every field
    // (not just valid) is reset; this keeps lookups defined straight out of reset.
    // NOTE: non-blocking assignments throughout so every update reads the
    // pre-edge table state, matching the lookup's no-bypass behaviour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                ctr_q[i] <= BP_CTR_INIT;
            end
        end else if (upd) begin
            if (wr_hit) begin
                ctr_q[wr_idx] <= ctr_next;
                if (ex_taken) tgt_q[wr_idx] <= ex_target;
            end else if (ex_taken) begin
                valid_q[wr_idx] <= 1'b1;
                tag_q[wr_idx]   <= wr_tag;
                tgt_q[wr_idx]   <= ex_target;
                ctr_q[wr_idx]   <= BP_CTR_ALLOC;
            end
        end
    end

    // ---------------- Performance counters ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt <= '0;
            mp_cnt <= '0;
        end else if (upd) begin
            br_cnt <= br_cnt + 32'd1;
            if (ex_mispredict) mp_cnt <= mp_cnt + 32'd1;
        end
    end

    // Low PC bits never select an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{ex_pc[1:0], if_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, async reset
// sequence, then randomized traffic against a behavioural BTB model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] if_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        ex_valid = 1'b0, ex_is_branch = 1'b0, ex_taken = 1'b0, ex_mispredict = 1'b0;
    logic [31:0] ex_pc = '0, ex_target = '0;
    logic [31:0] br_cnt, mp_cnt;

    int errors = 0;
    int checks = 0;

    branch_predictor dut (
        .clk           (clk),
        .rst           (rst),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .pred_pc       (pred_pc),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .ex_pc         (ex_pc),
        .ex_taken      (ex_taken),
        .ex_target     (ex_target),
        .ex_mispredict (ex_mispredict),
        .br_cnt        (br_cnt),
        .mp_cnt        (mp_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    typedef struct {
        logic [31:0] if_pc;
        logic        ev, br, tk, mp;
        logic [31:0] ex_pc, tgt;
        logic        e_pt;
        logic [31:0] e_ppc, e_br, e_mp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [31:0] ipc, input logic ev, input logic br,
                                input logic [31:0] epc, input logic tk, input logic [31:0] tgt,
                                input logic mp, input logic ept, input logic [31:0] eppc,
                                input logic [31:0] ebr, input logic [31:0] emp);
        vec_t v;
        v.if_pc = ipc; v.ev = ev; v.br = br; v.ex_pc = epc; v.tk = tk; v.tgt = tgt; v.mp = mp;
        v.e_pt = ept; v.e_ppc = eppc; v.e_br = ebr; v.e_mp = emp;
        return v;
    endfunction

    task automatic drive(input logic [31:0] ipc, input logic ev, input logic br,
                         input logic [31:0] epc, input logic tk, input logic [31:0] tgt,
                         input logic mp);
        if_pc = ipc; ex_valid = ev; ex_is_branch = br; ex_pc = epc;
        ex_taken = tk; ex_target = tgt; ex_mispredict = mp;
    endtask

    // ---------------- Behavioural reference model ----------------
    bit          m_valid [64];
    int unsigned m_tag   [64];
    int unsigned m_tgt   [64];
    int          m_ctr   [64];
    int unsigned m_br, m_mp;

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_br = 0; m_mp = 0;
    endfunction

    function automatic int unsigned slot(input int unsigned pc);
        return (pc / 4) % 64;
    endfunction

    function automatic bit model_pt(input int unsigned pc);
        int unsigned s = slot(pc);
        return m_valid[s] && m_tag[s] == pc / 256 && m_ctr[s] >= 2;
    endfunction

    function automatic int unsigned model_ppc(input int unsigned pc);
        int unsigned n = model_pt(pc) ? m_tgt[slot(pc)] : pc + 4;
        return n - (n % 4);
    endfunction

    function automatic void model_update(input int unsigned pc, input bit tk,
                                         input int unsigned tgt, input bit mp);
        int unsigned s = slot(pc);
        m_br++;
        if (mp) m_mp++;
        if (m_valid[s] && m_tag[s] == pc / 256) begin
            if (tk) begin
                m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
                m_tgt[s] = tgt;
            end else begin
                m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
            end
        end else if (tk) begin
            m_valid[s] = 1; m_tag[s] = pc / 256; m_tgt[s] = tgt; m_ctr[s] = 2;
        end
    endfunction

    initial begin
        // Each row: lookup and counters are checked before that row's edge.
        vecs.push_back(mk(32'h1C000000, 0,0, 32'h0,        0, 32'h0,        0, 0, 32'h1C000004, 0, 0));
        vecs.push_back(mk(32'h1C000000, 1,1, 32'h1C000010, 1, 32'h1C000100, 1, 0, 32'h1C000004, 0, 0));
        vecs.push_back(mk(32'h1C000010, 0,0, 32'h0,        0, 32'h0,        0, 1, 32'h1C000100, 1, 1));
        vecs.push_back(mk(32'h1C000010, 1,1, 32'h1C000010, 0, 32'h0,        1, 1, 32'h1C000100, 1, 1));
        vecs.push_back(mk(32'h1C000010, 1,1, 32'h1C000010, 0, 32'h0,        0, 0, 32'h1C000014, 2, 2));
        vecs.push_back(mk(32'h1C000010, 1,1, 32'h1C000010, 1, 32'h1C000100, 1, 0, 32'h1C000014, 3, 2));
        vecs.push_back(mk(32'h1C000010, 1,1, 32'h1C000010, 1, 32'h1C000100, 1, 0, 32'h1C000014, 4, 3));
        vecs.push_back(mk(32'h1C000010, 1,1, 32'h1C000010, 1, 32'h1C000100, 0, 1, 32'h1C000100, 5, 4));
        vecs.push_back(mk(32'h1C000010, 1,1, 32'h1C000010, 1, 32'h1C000100, 0, 1, 32'h1C000100, 6, 4));
        vecs.push_back(mk(32'h1C000010, 1,1, 32'h1C000010, 0, 32'h0,        1, 1, 32'h1C000100, 7, 4));
        vecs.push_back(mk(32'h1C000010, 0,0, 32'h0,        0, 32'h0,        0, 1, 32'h1C000100, 8, 5));
        vecs.push_back(mk(32'h1C000110, 0,0, 32'h0,        0, 32'h0,        0, 0, 32'h1C000114, 8, 5));
        vecs.push_back(mk(32'h1C000010, 1,1, 32'h1C000010, 1, 32'h1C000200, 1, 1, 32'h1C000100, 8, 5));
        vecs.push_back(mk(32'h1C000010, 0,0, 32'h0,        0, 32'h0,        0, 1, 32'h1C000200, 9, 6));
        vecs.push_back(mk(32'h1C000020, 1,1, 32'h1C000020, 0, 32'h1C000500, 1, 0, 32'h1C000024, 9, 6));
        vecs.push_back(mk(32'h1C000020, 0,0, 32'h0,        0, 32'h0,        0, 0, 32'h1C000024, 10, 7));
        vecs.push_back(mk(32'h00000000, 1,0, 32'h1C000030, 1, 32'h1C000600, 1, 0, 32'h00000004, 10, 7));
        vecs.push_back(mk(32'h1C000030, 0,1, 32'h1C000030, 1, 32'h1C000600, 1, 0, 32'h1C000034, 10, 7));
        vecs.push_back(mk(32'hFFFFFFFC, 0,0, 32'h0,        0, 32'h0,        0, 0, 32'h00000000, 10, 7));
        vecs.push_back(mk(32'h1C000030, 0,0, 32'h0,        0, 32'h0,        0, 0, 32'h1C000034, 10, 7));
        vecs.push_back(mk(32'h1C000110, 1,1, 32'h1C000110, 1, 32'h1C000300, 0, 0, 32'h1C000114, 10, 7));
        vecs.push_back(mk(32'h1C000010, 0,0, 32'h0,        0, 32'h0,        0, 0, 32'h1C000014, 11, 7));
        vecs.push_back(mk(32'h1C000110, 0,0, 32'h0,        0, 32'h0,        0, 1, 32'h1C000300, 11, 7));

        // Reset state.
        drive(32'h1C000000, 0, 0, 0, 0, 0, 0);
        #1;
        check("reset_pred_taken", {31'b0, pred_taken}, 32'h0);
        check("reset_pred_pc", pred_pc, 32'h1C000004);
        check("reset_br_cnt", br_cnt, 32'h0);
        check("reset_mp_cnt", mp_cnt, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].if_pc, vecs[k].ev, vecs[k].br, vecs[k].ex_pc,
                  vecs[k].tk, vecs[k].tgt, vecs[k].mp);
            #1;
            check($sformatf("vec%0d_pred_taken", k), {31'b0, pred_taken}, {31'b0, vecs[k].e_pt});
            check($sformatf("vec%0d_pred_pc", k), pred_pc, vecs[k].e_ppc);
            check($sformatf("vec%0d_br_cnt", k), br_cnt, vecs[k].e_br);
            check($sformatf("vec%0d_mp_cnt", k), mp_cnt, vecs[k].e_mp);
            @(posedge clk);
        end

        // Async reset mid-run: clears between edges, no clock needed.
        @(negedge clk);
        drive(32'h1C000110, 0, 0, 0, 0, 0, 0);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_pred_taken", {31'b0, pred_taken}, 32'h0);
        check("midrst_pred_pc", pred_pc, 32'h1C000114);
        check("midrst_br_cnt", br_cnt, 32'h0);
        check("midrst_mp_cnt", mp_cnt, 32'h0);
        #1;
        rst = 1'b1;

        // First edge after release performs a normal update.
        @(negedge clk);
        drive(32'h1C000040, 1, 1, 32'h1C000040, 1, 32'h1C000400, 1);
        @(negedge clk);
        drive(32'h1C000040, 0, 0, 0, 0, 0, 0);
        #1;
        check("postrst_pred_taken", {31'b0, pred_taken}, 32'h1);
        check("postrst_pred_pc", pred_pc, 32'h1C000400);
        check("postrst_br_cnt", br_cnt, 32'h1);
        check("postrst_mp_cnt", mp_cnt, 32'h1);

        // Randomized traffic against the model, starting from a fresh reset.
        @(negedge clk);
        rst = 1'b0;
        #1;
        rst = 1'b1;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            int unsigned ipc, epc, tgt;
            bit ev, br, tk, mp;
            @(negedge clk);
            ipc = 32'h1C000000 + ($urandom_range(0, 3) << 8) + ($urandom_range(0, 7) << 2);
            epc = 32'h1C000000 + ($urandom_range(0, 3) << 8) + ($urandom_range(0, 7) << 2);
            if ($urandom_range(0, 15) == 0) ipc = 32'hFFFFFFFC;
            tgt = $urandom;
            ev = ($urandom_range(0, 3) != 0);
            br = ($urandom_range(0, 3) != 0);
            tk = $urandom_range(0, 1);
            mp = $urandom_range(0, 1);
            drive(ipc, ev, br, epc, tk, tgt, mp);
            #1;
            check("rnd_pred_taken", {31'b0, pred_taken}, {31'b0, model_pt(ipc)});
            check("rnd_pred_pc", pred_pc, model_ppc(ipc));
            check("rnd_br_cnt", br_cnt, m_br);
            check("rnd_mp_cnt", mp_cnt, m_mp);
            @(posedge clk);
            if (ev && br) model_update(epc, tk, tgt, mp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
